rx_lane_sync_ctrl: RTL and testbench

Per-lane receive synchronisation controller that sequences the 64B/67B decoder. It resets the decoder and times out if the decoder fails to reach block lock. Once the decoder reports lock, it hunts for the Interlaken metaframe sync word and declares the lane aligned. It sits between the decoder output and the lane deskew logic, drives the decoder's reset and passthrough controls, and exposes per-lane status and retry counters.

---
 rtl/rx_lane_sync_ctrl_pkg.sv | 51 +++++
 rtl/rx_lane_sync_ctrl_if.sv | 40 ++++
 rtl/rx_lane_sync_ctrl_mf_sync_checker.sv | 92 +++++++++
 rtl/rx_lane_sync_ctrl.sv | 154 +++++++++++++++
 tb/tb_rx_lane_sync_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_lane_sync_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lane_sync_pkg
// Shared definitions for the per-lane receive synchronisation controller and
// its metaframe sync checker: default parameter values, bus widths, the
// Interlaken metaframe sync word, 64B/67B header codes, the controller state
// encoding and the checker operating modes.
// No ports (package).
// -----------------------------------------------------------------------------
package lane_sync_pkg;

    localparam int MF_LEN_DEFAULT         = 2048;
    localparam int LOCK_TIMEOUT_DEFAULT   = 4096;
    localparam int DEC_RST_CYCLES_DEFAULT = 8;
    localparam int SYNC_GOOD_DEFAULT      = 4;
    localparam int SYNC_MISS_DEFAULT      = 4;

    localparam int DATA_W  = 64;
    localparam int HDR_W   = 2;
    localparam int STATE_W = 3;

    // Bits [63:58] = 6'b011110, bits [57:0] = 58'h0F678F678F678F6.
    localparam logic [DATA_W-1:0] SYNC_WORD = 64'h78F6_78F6_78F6_78F6;
    localparam logic [HDR_W-1:0]  HDR_CTRL  = 2'b10;
    localparam logic [HDR_W-1:0]  HDR_DATA  = 2'b01;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_DEC_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_HUNT      = 3'd3,
        ST_VERIFY    = 3'd4,
        ST_ALIGNED   = 3'd5,
        ST_BYPASS    = 3'd6
    } lane_state_e;

    // Checker modes are kept separate from the controller states so the
    // checker can be driven by other sequencers (diagnostic-word checking).
    typedef enum logic [1:0] {
        CHK_OFF,
        CHK_HUNT,
        CHK_VERIFY,
        CHK_ALIGNED
    } chk_mode_e;

    function automatic logic is_sync_word(input logic              valid,
                                          input logic [HDR_W-1:0]  header,
                                          input logic [DATA_W-1:0] data);
        return valid && (header == HDR_CTRL) && (data == SYNC_WORD);
    endfunction

endpackage

// File: rtl/rx_lane_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_lane_sync_ctrl_if
// Bundles the decoder-facing inputs and the control/status outputs of the lane
// sync controller.
//   master : decoder/system side - drives ENABLE, BYPASS_REQ, DEC_VALID,
//            DEC_LOCKED, DEC_HEADER, DEC_DATA; observes the controller outputs.
//   slave  : the controller - drives DEC_RESET, DEC_PASSTHROUGH, LANE_ALIGNED,
//            MF_START, STATE, RETRY_CNT, MISS_CNT.
// -----------------------------------------------------------------------------
interface rx_lane_sync_ctrl_if;
    import lane_sync_pkg::*;

    logic               ENABLE;
    logic               BYPASS_REQ;
    logic               DEC_VALID;
    logic               DEC_LOCKED;
    logic [HDR_W-1:0]   DEC_HEADER;
    logic [DATA_W-1:0]  DEC_DATA;

    logic               DEC_RESET;
    logic               DEC_PASSTHROUGH;
    logic               LANE_ALIGNED;
    logic               MF_START;
    logic [STATE_W-1:0] STATE;
    logic [7:0]         RETRY_CNT;
    logic [15:0]        MISS_CNT;

    modport master (
        output ENABLE, BYPASS_REQ, DEC_VALID, DEC_LOCKED, DEC_HEADER, DEC_DATA,
        input  DEC_RESET, DEC_PASSTHROUGH, LANE_ALIGNED, MF_START, STATE,
               RETRY_CNT, MISS_CNT
    );

    modport slave (
        input  ENABLE, BYPASS_REQ, DEC_VALID, DEC_LOCKED, DEC_HEADER, DEC_DATA,
        output DEC_RESET, DEC_PASSTHROUGH, LANE_ALIGNED, MF_START, STATE,
               RETRY_CNT, MISS_CNT
    );

endinterface

// File: rtl/rx_lane_sync_ctrl_mf_sync_checker.sv
// -----------------------------------------------------------------------------
// mf_sync_checker
// Tracks metaframe position on the decoded word stream and qualifies sync
// words. Holds the word counter (index of the last accepted valid word within
// the metaframe, sync word = index 0) and the good/miss run counters. All event
// outputs are combinational and qualified by 'en'; the owning FSM registers
// whatever it derives from them.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   mode           : CHK_OFF / CHK_HUNT / CHK_VERIFY / CHK_ALIGNED
//   en             : qualifies all events (low = abort in progress, no updates)
//   word_valid/header/data : decoder word stream
//   hunt_hit       : sync word seen while hunting (counter loaded with 0)
//   sync_ok        : sync word present at the sync position
//   sync_bad       : sync position reached without a sync word
//   good_done      : sync_ok that completes the SYNC_GOOD run (VERIFY)
//   miss_done      : sync_bad that completes the SYNC_MISS run (ALIGNED)
// -----------------------------------------------------------------------------
module mf_sync_checker
    import lane_sync_pkg::*;
#(
    parameter int MF_LEN    = MF_LEN_DEFAULT,
    parameter int SYNC_GOOD = SYNC_GOOD_DEFAULT,
    parameter int SYNC_MISS = SYNC_MISS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  chk_mode_e         mode,
    input  logic              en,
    input  logic              word_valid,
    input  logic [HDR_W-1:0]  word_header,
    input  logic [DATA_W-1:0] word_data,
    output logic              hunt_hit,
    output logic              sync_ok,
    output logic              sync_bad,
    output logic              good_done,
    output logic              miss_done
);

    localparam int               CNT_W     = $clog2(MF_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MF_LEN - 1);
    localparam logic [2:0]       GOOD_LAST = 3'(SYNC_GOOD - 1);
    localparam logic [2:0]       MISS_LAST = 3'(SYNC_MISS - 1);

    logic [CNT_W-1:0] word_idx;
    logic [2:0]       good_cnt;
    logic [2:0]       miss_cnt;
    logic             match;
    logic             tracking;
    logic             at_sync;

    assign match    = is_sync_word(word_valid, word_header, word_data);
    assign tracking = en && ((mode == CHK_VERIFY) || (mode == CHK_ALIGNED));
    // The sync position is the valid word that follows index MF_LEN-1; an
    // invalid cycle there simply defers the check to the next valid word.
    assign at_sync  = tracking && word_valid && (word_idx == LAST_IDX);

    assign hunt_hit  = en && (mode == CHK_HUNT) && match;
    assign sync_ok   = at_sync && match;
    assign sync_bad  = at_sync && !match;
    assign good_done = (mode == CHK_VERIFY)  && sync_ok  && (good_cnt == GOOD_LAST);
    assign miss_done = (mode == CHK_ALIGNED) && sync_bad && (miss_cnt == MISS_LAST);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (hunt_hit) begin
                word_idx <= '0;
            end else if (tracking && word_valid) begin
                word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
            end

            if (hunt_hit) begin
                good_cnt <= 3'd1;
            end else if ((mode == CHK_VERIFY) && sync_ok) begin
                good_cnt <= good_cnt + 3'd1;
            end

            if (good_done || ((mode == CHK_ALIGNED) && sync_ok)) begin
                miss_cnt <= '0;
            end else if ((mode == CHK_ALIGNED) && sync_bad) begin
                miss_cnt <= miss_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// -----------------------------------------------------------------------------
// rx_lane_sync_ctrl
// Per-lane receive sync controller: pulses the 64B/67B decoder reset, waits for
// block lock with a timeout, hunts/verifies the metaframe sync word and reports
// lane alignment. All outputs are registered.
// Ports:
//   USER_CLK        : lane clock
//   SYSTEM_RESET_N  : asynchronous active-low reset
//   bus (slave)     : ENABLE, BYPASS_REQ, DEC_VALID, DEC_LOCKED, DEC_HEADER,
//                     DEC_DATA in; DEC_RESET, DEC_PASSTHROUGH, LANE_ALIGNED,
//                     MF_START, STATE, RETRY_CNT, MISS_CNT out
// -----------------------------------------------------------------------------
module rx_lane_sync_ctrl
    import lane_sync_pkg::*;
#(
    parameter int MF_LEN         = MF_LEN_DEFAULT,
    parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEFAULT,
    parameter int DEC_RST_CYCLES = DEC_RST_CYCLES_DEFAULT,
    parameter int SYNC_GOOD      = SYNC_GOOD_DEFAULT,
    parameter int SYNC_MISS      = SYNC_MISS_DEFAULT
) (
    input  logic                USER_CLK,
    input  logic                SYSTEM_RESET_N,
    rx_lane_sync_ctrl_if.slave  bus
);

    // One timer serves both the reset pulse and the lock timeout.
    localparam int TIMER_SPAN = (LOCK_TIMEOUT > DEC_RST_CYCLES) ? LOCK_TIMEOUT : DEC_RST_CYCLES;
    localparam int TIMER_W    = $clog2(TIMER_SPAN);
    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(DEC_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);

    lane_state_e        state;
    lane_state_e        state_nxt;
    logic [TIMER_W-1:0] timer;
    logic               dec_reset;
    logic               passthrough;
    logic               lane_aligned;
    logic               mf_start;
    logic [7:0]         retry_cnt;
    logic [15:0]        miss_cnt;

    chk_mode_e chk_mode;
    logic      track_en;
    logic      hunt_hit;
    logic      sync_ok;
    logic      sync_bad;
    logic      good_done;
    logic      miss_done;

    // Losing lock or enable aborts the cycle's sync check entirely.
    assign track_en = bus.ENABLE && bus.DEC_LOCKED;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        chk_mode = CHK_OFF;
        case (state)
            ST_HUNT:    chk_mode = CHK_HUNT;
            ST_VERIFY:  chk_mode = CHK_VERIFY;
            ST_ALIGNED: chk_mode = CHK_ALIGNED;
            default:    ;
        endcase
    end

    mf_sync_checker #(
        .MF_LEN    (MF_LEN),
        .SYNC_GOOD (SYNC_GOOD),
        .SYNC_MISS (SYNC_MISS)
    ) u_checker (
        .clk         (USER_CLK),
        .rst_n       (SYSTEM_RESET_N),
        .mode        (chk_mode),
        .en          (track_en),
        .word_valid  (bus.DEC_VALID),
        .word_header (bus.DEC_HEADER),
        .word_data   (bus.DEC_DATA),
        .hunt_hit    (hunt_hit),
        .sync_ok     (sync_ok),
        .sync_bad    (sync_bad),
        .good_done   (good_done),
        .miss_done   (miss_done)
    );

    always_comb begin
        state_nxt = state;
        if (!bus.ENABLE) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      state_nxt = bus.BYPASS_REQ ? ST_BYPASS : ST_DEC_RST;
                ST_BYPASS:    if (!bus.BYPASS_REQ) state_nxt = ST_IDLE;
                ST_DEC_RST:   if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (bus.DEC_LOCKED)           state_nxt = ST_HUNT;
                    else if (timer == TIMEOUT_LAST) state_nxt = ST_DEC_RST;
                end
                ST_HUNT: begin
                    if (!bus.DEC_LOCKED) state_nxt = ST_DEC_RST;
                    else if (hunt_hit)   state_nxt = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (!bus.DEC_LOCKED) state_nxt = ST_DEC_RST;
                    else if (good_done)  state_nxt = ST_ALIGNED;
                    else if (sync_bad)   state_nxt = ST_HUNT;
                end
                ST_ALIGNED: begin
                    if (!bus.DEC_LOCKED) state_nxt = ST_DEC_RST;
                    else if (miss_done)  state_nxt = ST_HUNT;
                end
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with STATE.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state        <= ST_IDLE;
            timer        <= '0;
            dec_reset    <= 1'b0;
            passthrough  <= 1'b0;
            lane_aligned <= 1'b0;
            mf_start     <= 1'b0;
            retry_cnt    <= '0;
            miss_cnt     <= '0;
        end else begin
            state <= state_nxt;
            // Restarts on every state change; only read in DEC_RST/WAIT_LOCK.
            timer <= (state_nxt != state) ? '0 : timer + 1'b1;

            dec_reset    <= (state_nxt == ST_DEC_RST);
            passthrough  <= (state_nxt == ST_BYPASS);
            lane_aligned <= (state_nxt == ST_ALIGNED);
            mf_start     <= (state == ST_ALIGNED) && sync_ok;

            if ((state_nxt == ST_DEC_RST) && (state != ST_DEC_RST) && (retry_cnt != 8'hFF)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if ((state == ST_ALIGNED) && sync_bad && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign bus.DEC_RESET       = dec_reset;
    assign bus.DEC_PASSTHROUGH = passthrough;
    assign bus.LANE_ALIGNED    = lane_aligned;
    assign bus.MF_START        = mf_start;
    assign bus.STATE           = state;
    assign bus.RETRY_CNT       = retry_cnt;
    assign bus.MISS_CNT        = miss_cnt;

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_lane_sync_ctrl
// Directed bench for rx_lane_sync_ctrl with a behavioural reference model and
// a per-cycle output comparison, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_rx_lane_sync_ctrl;
    import lane_sync_pkg::*;

    localparam int MF  = 2048;
    localparam int LT  = 4096;
    localparam int DRC = 8;
    localparam int SG  = 4;
    localparam int SM  = 4;

    localparam int S_IDLE = 0, S_DEC_RST = 1, S_WAIT = 2, S_HUNT = 3,
                   S_VERIFY = 4, S_ALIGNED = 5, S_BYPASS = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks  = 0;
    int n_errors  = 0;
    int mf_pulses = 0;

    // Reference model state
    int m_st      = S_IDLE;
    int m_t       = 0;
    int m_since   = 0;
    int m_good    = 0;
    int m_miss    = 0;
    int m_retry   = 0;
    int m_misscnt = 0;
    bit e_mfs     = 1'b0;

    rx_lane_sync_ctrl_if bus ();

    rx_lane_sync_ctrl #(
        .MF_LEN         (MF),
        .LOCK_TIMEOUT   (LT),
        .DEC_RST_CYCLES (DRC),
        .SYNC_GOOD      (SG),
        .SYNC_MISS      (SM)
    ) dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .bus            (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spec-level rules, evaluated on each rising edge with the
    // inputs that were presented to that edge.
    initial begin : model
        int ns;
        bit hit;
        bit mfs;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_st = S_IDLE; m_t = 0; m_since = 0; m_good = 0; m_miss = 0;
                m_retry = 0; m_misscnt = 0; e_mfs = 1'b0;
            end else begin
                ns  = m_st;
                mfs = 1'b0;
                hit = bus.DEC_VALID && (bus.DEC_HEADER == HDR_CTRL) && (bus.DEC_DATA == SYNC_WORD);
                if (!bus.ENABLE) ns = S_IDLE;
                else if (m_st == S_IDLE) ns = bus.BYPASS_REQ ? S_BYPASS : S_DEC_RST;
                else if (m_st == S_BYPASS) begin
                    if (!bus.BYPASS_REQ) ns = S_IDLE;
                end else if (m_st == S_DEC_RST) begin
                    if (m_t == DRC - 1) ns = S_WAIT;
                end else if (m_st == S_WAIT) begin
                    if (bus.DEC_LOCKED) ns = S_HUNT;
                    else if (m_t == LT - 1) ns = S_DEC_RST;
                end else if (!bus.DEC_LOCKED) ns = S_DEC_RST;
                else if (m_st == S_HUNT) begin
                    if (hit) begin m_since = 0; m_good = 1; ns = S_VERIFY; end
                end else if (bus.DEC_VALID) begin
                    m_since++;
                    if (m_since % MF == 0) begin
                        if (m_st == S_VERIFY) begin
                            if (!hit) ns = S_HUNT;
                            else begin
                                m_good++;
                                if (m_good == SG) begin ns = S_ALIGNED; m_miss = 0; end
                            end
                        end else if (hit) begin
                            mfs = 1'b1; m_miss = 0;
                        end else begin
                            m_miss++;
                            if (m_misscnt < 65535) m_misscnt++;
                            if (m_miss == SM) ns = S_HUNT;
                        end
                    end
                end
                if (ns == S_DEC_RST && m_st != S_DEC_RST && m_retry < 255) m_retry++;
                m_t   = (ns == m_st) ? m_t + 1 : 0;
                m_st  = ns;
                e_mfs = mfs;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare
        logic [30:0] dut_vec;
        logic [30:0] exp_vec;
        forever begin
            @(negedge clk);
            dut_vec = {bus.DEC_RESET, bus.DEC_PASSTHROUGH, bus.LANE_ALIGNED, bus.MF_START,
                       bus.STATE, bus.RETRY_CNT, bus.MISS_CNT};
            exp_vec = {m_st == S_DEC_RST, m_st == S_BYPASS, m_st == S_ALIGNED, e_mfs,
                       3'(m_st), 8'(m_retry), 16'(m_misscnt)};
            check("outputs_vs_model", 64'(dut_vec), 64'(exp_vec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (bus.MF_START) mf_pulses++;
    endtask

    task automatic send_word(input logic v, input logic [1:0] hdr, input logic [63:0] data);
        bus.DEC_VALID  = v;
        bus.DEC_HEADER = hdr;
        bus.DEC_DATA   = data;
        tick();
    endtask

    task automatic send_sync();
        send_word(1'b1, HDR_CTRL, SYNC_WORD);
    endtask

    task automatic send_bad_sync();
        send_word(1'b1, HDR_CTRL, SYNC_WORD ^ 64'h1);
    endtask

    // n valid data words, with a gearbox-slip invalid cycle every 700 words.
    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 700 == 699) send_word(1'b0, HDR_DATA, 64'h0);
            send_word(1'b1, HDR_DATA, {32'(i), 32'hA5A5_0000 ^ 32'(i)});
        end
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        for (int i = 0; i < budget && int'(bus.STATE) != target; i++) tick();
        check(name, 64'(bus.STATE), 64'(target));
    endtask

    initial begin : stimulus
        int rst_len;
        int wait_cycles;
        int retry_at_wait;
        bit seen_wait;
        int p0;

        bus.ENABLE = 1'b0; bus.BYPASS_REQ = 1'b0; bus.DEC_VALID = 1'b0;
        bus.DEC_LOCKED = 1'b0; bus.DEC_HEADER = HDR_DATA; bus.DEC_DATA = '0;
        repeat (3) tick();
        check("reset_outputs",
              64'({bus.DEC_RESET, bus.DEC_PASSTHROUGH, bus.LANE_ALIGNED, bus.MF_START,
                   bus.STATE, bus.RETRY_CNT, bus.MISS_CNT}), 64'd0);

        // Reset release with ENABLE=1 and no lock: pulse length, then timeout.
        bus.ENABLE = 1'b1;
        rst_n = 1'b1;
        rst_len = 0; wait_cycles = 0; retry_at_wait = 0; seen_wait = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (!seen_wait && bus.DEC_RESET) rst_len++;
            if (int'(bus.STATE) == S_WAIT) begin
                if (!seen_wait) retry_at_wait = int'(bus.RETRY_CNT);
                seen_wait = 1'b1;
                wait_cycles++;
            end
            if (seen_wait && int'(bus.STATE) == S_DEC_RST) break;
        end
        check("dec_reset_len", 64'(rst_len), 64'd8);
        check("retry_after_first_reset", 64'(retry_at_wait), 64'd1);
        check("lock_timeout_cycles", 64'(wait_cycles), 64'd4096);
        check("retry_after_timeout", 64'(bus.RETRY_CNT), 64'd2);
        check("dec_reset_reasserted", 64'(bus.DEC_RESET), 64'd1);

        // Lock and hunt; first sync enters VERIFY.
        bus.DEC_LOCKED = 1'b1;
        wait_state(S_HUNT, 50, "reach_hunt");
        send_data(5);
        send_sync();
        check("verify_after_first_sync", 64'(bus.STATE), 64'(S_VERIFY));
        // Second metaframe carries a misplaced sync word that must be ignored.
        send_data(100);
        send_sync();
        send_data(MF - 102);
        send_sync();
        check("still_verify_2nd_sync", 64'(bus.STATE), 64'(S_VERIFY));
        for (int k = 0; k < 2; k++) begin
            send_data(MF - 1);
            send_sync();
        end
        check("aligned_after_4th_sync", 64'(bus.LANE_ALIGNED), 64'd1);
        check("no_mf_start_on_entry", 64'(bus.MF_START), 64'd0);

        // Two aligned metaframes: one MF_START per metaframe.
        p0 = mf_pulses;
        for (int k = 0; k < 2; k++) begin
            send_data(MF - 1);
            send_sync();
            check("mf_start_pulse", 64'(bus.MF_START), 64'd1);
        end
        check("mf_start_count", 64'(mf_pulses - p0), 64'd2);

        // Invalid cycle on the sync position defers the check.
        send_data(MF - 1);
        send_word(1'b0, HDR_CTRL, SYNC_WORD ^ 64'hFF);
        check("deferred_no_miss", 64'(bus.MISS_CNT), 64'd0);
        send_sync();
        check("deferred_mf_start", 64'(bus.MF_START), 64'd1);
        check("deferred_miss_cnt", 64'(bus.MISS_CNT), 64'd0);

        // Three misses stay aligned, the fourth drops to HUNT.
        for (int k = 0; k < 3; k++) begin
            send_data(MF - 1);
            send_bad_sync();
        end
        check("aligned_after_3_miss", 64'(bus.LANE_ALIGNED), 64'd1);
        check("miss_cnt_3", 64'(bus.MISS_CNT), 64'd3);
        send_data(MF - 1);
        send_bad_sync();
        check("hunt_after_4_miss", 64'(bus.STATE), 64'(S_HUNT));
        check("unaligned_after_4_miss", 64'(bus.LANE_ALIGNED), 64'd0);
        check("miss_cnt_4", 64'(bus.MISS_CNT), 64'd4);

        // Lock loss coinciding with a matching sync in VERIFY wins.
        send_sync();
        check("verify_again", 64'(bus.STATE), 64'(S_VERIFY));
        send_data(MF - 1);
        bus.DEC_LOCKED = 1'b0;
        send_sync();
        check("lock_loss_state", 64'(bus.STATE), 64'(S_DEC_RST));
        check("lock_loss_dec_reset", 64'(bus.DEC_RESET), 64'd1);
        check("lock_loss_retry", 64'(bus.RETRY_CNT), 64'd3);
        check("model_retry_pin", 64'(m_retry), 64'd3);

        // ENABLE low forces IDLE; bypass request then selects passthrough.
        bus.DEC_VALID = 1'b0;
        bus.ENABLE = 1'b0;
        tick();
        check("disable_to_idle", 64'(bus.STATE), 64'(S_IDLE));
        bus.BYPASS_REQ = 1'b1;
        bus.ENABLE = 1'b1;
        tick();
        check("bypass_state", 64'(bus.STATE), 64'(S_BYPASS));
        check("bypass_passthrough", 64'(bus.DEC_PASSTHROUGH), 64'd1);
        tick();
        check("bypass_hold", 64'(bus.STATE), 64'(S_BYPASS));
        bus.BYPASS_REQ = 1'b0;
        tick();
        check("bypass_exit", 64'(bus.STATE), 64'(S_IDLE));
        check("bypass_exit_passthrough", 64'(bus.DEC_PASSTHROUGH), 64'd0);
        bus.ENABLE = 1'b0;
        tick();
        check("final_idle", 64'(bus.STATE), 64'(S_IDLE));
        check("model_state_pin", 64'(m_st), 64'(S_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
